// File: rtl/vmips_pc_seq.sv
// Program-counter sequencer: IDLE/RUN/HALT control, branch redirect, stall hold
// and a single-level zero-overhead hardware loop.
module vmips_pc_seq #(
  parameter int                  ADDR_W   = 32,
  parameter int                  STEP     = 4,
  parameter int                  CNT_W    = 8,
  parameter logic [ADDR_W-1:0]   RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              loop_set,
  input  logic [ADDR_W-1:0] loop_end,
  input  logic [CNT_W-1:0]  loop_count,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] nPC,
  output logic              valid,
  output logic              loop_active,
  output logic [CNT_W-1:0]  loop_left,
  output logic              loop_err
);

  localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] loop_begin;
  logic [ADDR_W-1:0] loop_last;
  logic [ADDR_W-1:0] seq_pc;
  logic              at_end;
  logic              loop_back;

  assign seq_pc    = PC + STEP_V;
  assign at_end    = loop_active && (PC == loop_last) && !br_taken;
  assign loop_back = at_end && (loop_left > CNT_ONE);

  // Next fetch address; frozen outside RUN so nPC mirrors PC there.
  always_comb begin
    nPC = PC;
    if (state == RUN) begin
      if (br_taken) begin
        nPC = br_target;
      end else if (loop_back) begin
        nPC = loop_begin;
      end else begin
        nPC = seq_pc;
      end
    end else begin
      nPC = PC;
    end
  end

  // Control FSM, PC register and loop bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      PC          <= RESET_PC;
      valid       <= 1'b0;
      loop_active <= 1'b0;
      loop_left   <= CNT_ZERO;
      loop_err    <= 1'b0;
      loop_begin  <= {ADDR_W{1'b0}};
      loop_last   <= {ADDR_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            valid <= 1'b1;
          end
        end
        RUN: begin
          if (halt_req) begin
            state       <= HALT;
            valid       <= 1'b0;
            loop_active <= 1'b0;
          end else if (!stall) begin
            PC <= nPC;
            // Final pass through the body falls through and disarms the loop.
            if (loop_back) begin
              loop_left <= loop_left - CNT_ONE;
            end else if (at_end) begin
              loop_left   <= CNT_ZERO;
              loop_active <= 1'b0;
            end
            if (loop_set) begin
              if (loop_active) begin
                loop_err <= 1'b1;
              end else begin
                loop_begin  <= seq_pc;
                loop_last   <= loop_end;
                loop_left   <= (loop_count == CNT_ZERO) ? CNT_ONE : loop_count;
                loop_active <= 1'b1;
              end
            end
          end
        end
        HALT: begin
          valid <= 1'b0;
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vmips_pc_seq.sv
// Randomized and directed bench for vmips_pc_seq, checked against a cycle-level
// reference model of the sequencing rules.
module tb_vmips_pc_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, stall, br_taken, loop_set, halt_req;
  logic [31:0] br_target, loop_end;
  logic [7:0]  loop_count;
  logic [31:0] pc, npc;
  logic        valid, loop_active, loop_err;
  logic [7:0]  loop_left;

  logic        rst2, start2, halt2;
  logic [31:0] pc2, npc2;
  logic        valid2, la2, le2;
  logic [7:0]  ll2;

  vmips_pc_seq dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .loop_set(loop_set), .loop_end(loop_end),
    .loop_count(loop_count), .halt_req(halt_req), .PC(pc), .nPC(npc),
    .valid(valid), .loop_active(loop_active), .loop_left(loop_left), .loop_err(loop_err)
  );

  vmips_pc_seq #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst2), .start(start2), .stall(1'b0), .br_taken(1'b0),
    .br_target(32'h0), .loop_set(1'b0), .loop_end(32'h0), .loop_count(8'h0),
    .halt_req(halt2), .PC(pc2), .nPC(npc2), .valid(valid2), .loop_active(la2),
    .loop_left(ll2), .loop_err(le2)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: 0 = idle, 1 = run, 2 = halt.
  int          m_state;
  logic [31:0] m_pc, m_begin, m_end;
  logic [7:0]  m_left;
  bit          m_active, m_err;

  function automatic logic [31:0] model_npc();
    if (m_state != 1) return m_pc;
    if (br_taken) return br_target;
    if (m_active && m_pc == m_end && m_left > 8'd1) return m_begin;
    return m_pc + 32'd4;
  endfunction

  task automatic model_step();
    logic [31:0] nxt;
    bit was_active;
    if (rst) begin
      m_state = 0; m_pc = 32'h0; m_active = 0; m_left = 8'd0; m_err = 0;
    end else if (m_state == 0) begin
      if (start) m_state = 1;
    end else if (m_state == 1) begin
      if (halt_req) begin
        m_state = 2; m_active = 0;
      end else if (!stall) begin
        nxt = model_npc();
        was_active = m_active;
        if (m_active && m_pc == m_end && !br_taken) begin
          if (m_left > 8'd1) m_left = m_left - 8'd1;
          else begin m_left = 8'd0; m_active = 0; end
        end
        if (loop_set) begin
          if (was_active) m_err = 1;
          else begin
            m_begin = m_pc + 32'd4; m_end = loop_end;
            m_left = (loop_count == 8'd0) ? 8'd1 : loop_count;
            m_active = 1;
          end
        end
        m_pc = nxt;
      end
    end
  endtask

  task automatic clear_in();
    rst = 0; start = 0; stall = 0; br_taken = 0; loop_set = 0; halt_req = 0;
    br_target = 32'h0; loop_end = 32'h0; loop_count = 8'h0;
  endtask

  // Compare all outputs against the model, then advance one clock.
  task automatic cycle();
    @(negedge clk);
    check_val("pc", pc, m_pc);
    check_val("npc", npc, model_npc());
    check_val("valid", valid, m_state == 1);
    check_val("loop_active", loop_active, m_active);
    check_val("loop_left", loop_left, m_left);
    check_val("loop_err", loop_err, m_err);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1;
    @(posedge clk);
    model_step();
    #1;
    rst = 0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  logic [31:0] seq_exp [7];

  initial begin
    clear_in();
    rst = 1;
    rst2 = 1; start2 = 0; halt2 = 0;

    // Wrap-around and halt behaviour on the second instance.
    @(posedge clk); #1 rst2 = 0;
    check_val("wrap_reset_pc", pc2, 32'hFFFF_FFF8);
    check_val("wrap_reset_valid", valid2, 1'b0);
    start2 = 1;
    @(posedge clk); #1 start2 = 0;
    check_val("wrap_pc0", pc2, 32'hFFFF_FFF8);
    check_val("wrap_valid", valid2, 1'b1);
    @(posedge clk); #1;
    check_val("wrap_pc1", pc2, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    check_val("wrap_pc2", pc2, 32'h0000_0000);
    halt2 = 1;
    @(posedge clk); #1 halt2 = 0;
    check_val("halt_valid", valid2, 1'b0);
    check_val("halt_pc", pc2, 32'h0000_0000);
    start2 = 1;
    repeat (3) @(posedge clk);
    #1 start2 = 0;
    check_val("halt_start_ign_valid", valid2, 1'b0);
    check_val("halt_start_ign_pc", pc2, 32'h0000_0000);
    check_val("halt_npc", npc2, 32'h0000_0000);
    rst2 = 1;
    @(posedge clk); #1 rst2 = 0;
    check_val("halt_rst_pc", pc2, 32'hFFFF_FFF8);

    // Sequential fetch after start.
    do_reset();
    check_val("idle_valid", valid, 1'b0);
    start = 1; cycle(); start = 0;
    for (int i = 0; i < 4; i++) begin
      check_val("seq_pc", pc, 32'(4 * i));
      check_val("seq_valid", valid, 1'b1);
      cycle();
    end

    // Branch at PC=8 followed by a two-cycle stall.
    do_reset();
    start = 1; cycle(); start = 0;
    run_cycles(2);
    check_val("br_at", pc, 32'h8);
    br_taken = 1; br_target = 32'h100; cycle(); br_taken = 0;
    check_val("br_pc0", pc, 32'h100);
    stall = 1; cycle();
    check_val("br_pc1", pc, 32'h100);
    check_val("stall_valid", valid, 1'b1);
    cycle(); stall = 0;
    check_val("br_pc2", pc, 32'h100);
    cycle();
    check_val("br_pc3", pc, 32'h104);

    // Three-iteration loop, then a loop_count of zero.
    do_reset();
    start = 1; cycle(); start = 0;
    run_cycles(4);
    loop_set = 1; loop_end = 32'h18; loop_count = 8'd3; cycle(); loop_set = 0;
    seq_exp = '{32'h14, 32'h18, 32'h14, 32'h18, 32'h14, 32'h18, 32'h1C};
    for (int i = 0; i < 7; i++) begin
      check_val("loop_seq", pc, seq_exp[i]);
      check_val("loop_act_seq", loop_active, i < 6);
      if (i < 6) cycle();
    end
    loop_set = 1; loop_end = 32'h24; loop_count = 8'd0; cycle(); loop_set = 0;
    check_val("loop0_left", loop_left, 8'd1);
    run_cycles(2);
    check_val("loop0_pc", pc, 32'h28);
    check_val("loop0_active", loop_active, 1'b0);

    // Re-arm error and branch at loop end.
    loop_set = 1; loop_end = 32'h30; loop_count = 8'd2; cycle();
    loop_end = 32'h40; cycle(); loop_set = 0;
    check_val("err_set", loop_err, 1'b1);
    check_val("err_pc", pc, 32'h30);
    br_taken = 1; br_target = 32'h200; cycle(); br_taken = 0;
    check_val("endbr_pc", pc, 32'h200);
    check_val("endbr_left", loop_left, 8'd2);
    check_val("endbr_active", loop_active, 1'b1);
    run_cycles(3);
    check_val("err_sticky", loop_err, 1'b1);

    // Reset mid-loop while stalled.
    loop_set = 1; loop_end = 32'h220; loop_count = 8'd4; cycle(); loop_set = 0;
    stall = 1; rst = 1; cycle(); rst = 0; stall = 0;
    check_val("rst_pc", pc, 32'h0);
    check_val("rst_valid", valid, 1'b0);
    check_val("rst_active", loop_active, 1'b0);
    check_val("rst_left", loop_left, 8'd0);
    check_val("rst_err", loop_err, 1'b0);
    start = 1; cycle(); start = 0;
    check_val("rst_restart_pc", pc, 32'h0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      clear_in();
      rst      = ($urandom_range(0, 99) == 0);
      start    = ($urandom_range(0, 3) == 0);
      stall    = ($urandom_range(0, 4) == 0);
      halt_req = ($urandom_range(0, 149) == 0);
      br_taken = ($urandom_range(0, 9) == 0);
      br_target = {$urandom_range(0, 255), 2'b00};
      loop_set = ($urandom_range(0, 11) == 0);
      loop_end = m_pc + 32'($urandom_range(1, 4) * 4);
      loop_count = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0 && m_active) begin
        br_taken = 0;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
